handshake_core: RTL and testbench
=================================

Name: handshake_core

Overview:
- Single-entry relay between two word channels.
- Accepts a word from an upstream producer over a 4-phase en/rdy handshake (channel_in).
- Holds the word in a one-entry buffer.
- Forwards the word unchanged to a downstream consumer as a one-cycle en pulse gated by the consumer's rdy (channel_out).
- Sits between a data source and a sink to decouple their handshake timing.

Parameters:
- WIDTH, 32, data width of both channels.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- channel_in_data  in  WIDTH  producer data; valid while channel_in_en=1
- channel_in_en  in  1  producer request; held high until channel_in_rdy seen high
- channel_in_rdy  out  1  ack to producer; high from capture until channel_in_en returns low
- channel_out_data  out  WIDTH  data to consumer; valid when channel_out_en=1
- channel_out_en  out  1  one-cycle transfer pulse to consumer
- channel_out_rdy  in  1  consumer ready to accept

Behaviour:
- Reset (rst=0 at a rising edge):
  - channel_in_rdy=0, channel_out_en=0, channel_out_data=0.
  - Buffer empty (full=0); both FSMs in IDLE.
  - Applies mid-transfer too; any buffered word is discarded.
- All outputs are registered; no combinational input-to-output paths.
- Input FSM, states IN_IDLE and IN_ACK:
  - IN_IDLE: if channel_in_en=1 and full=0, capture channel_in_data into buf, set full=1, channel_in_rdy<=1, go to IN_ACK. Otherwise hold, with rdy=0.
  - IN_ACK: rdy stays 1 while channel_in_en=1. When channel_in_en=0, rdy<=0 and go to IN_IDLE.
  - A word is captured exactly once per en rising phase; en held high across IN_ACK never re-captures.
  - Minimum input handshake: 4 cycles per word with a producer that reacts in one cycle.
- Output FSM, states OUT_IDLE and OUT_SEND:
  - OUT_IDLE: if full=1 and channel_out_rdy=1, channel_out_data<=buf, channel_out_en<=1, go to OUT_SEND.
  - OUT_SEND: channel_out_en<=0, full<=0, go to OUT_IDLE. channel_out_data keeps its last value.
  - The en pulse is exactly 1 cycle; each word is emitted exactly once.
  - If channel_out_rdy=0, the word waits in buf indefinitely.
- Simultaneous events:
  - Capture is evaluated on the registered full flag. A word draining in OUT_SEND this cycle frees the buffer for capture from the next cycle.
  - Producer en while full=1: rdy stays 0 (backpressure) until the buffer empties.
- Data is passed through unmodified, WIDTH bits, no arithmetic.
- Ordering is FIFO (depth 1); no loss, no duplication.

Decomposition:
- Shared package: WIDTH default constant; in_state_t {IN_IDLE, IN_ACK}; out_state_t {OUT_IDLE, OUT_SEND}.
- One natural sub-module: handshake_core_rx, the input 4-phase receiver FSM plus capture register. The output pulse logic stays in the top.

Test Plan:
- Reset: hold rst=0 5 cycles with in_en=1 and out_rdy=1 -> in_rdy=0, out_en=0, out_data=0 throughout.
- Single word: producer drives data=123, en=1, out_rdy=1.
  - -> in_rdy rises 1 cycle after en.
  - -> in_rdy falls 1 cycle after en drops.
  - -> out_en pulses exactly 1 cycle with out_data=123.
- Streaming: producer re-asserts en=1 data=123 whenever in_rdy=0; consumer sets rdy=1 when out_en=0 and rdy=0 after a pulse.
  - -> one out_en pulse with 123 per completed input handshake, none duplicated.
  - -> over 50 cycles, count out == count in ±1.
- Backpressure: out_rdy=0, send word 0xA5A5A5A5, then hold en=1 with 0x5.
  - -> first word is acked.
  - -> second is not acked (in_rdy stays 0) and out_en stays 0.
  - -> on out_rdy=1: out pulse 0xA5A5A5A5, then second word acked and emitted.
- Sticky en: producer keeps en=1 for 10 cycles after ack -> in_rdy stays 1, only one word captured and emitted.
- Reset mid-operation: assert rst=0 while in IN_ACK with a word buffered.
  - -> all outputs 0.
  - -> the word is never emitted.
  - -> a fresh word 7 after reset is emitted normally.

Source files
------------

// File: rtl/handshake_core_pkg.sv
// Shared types and defaults for the single-entry handshake relay.
// Imported by the receiver and the top.
package handshake_core_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_SEND
    } out_state_t;

endpackage

// File: rtl/handshake_core_rx.sv
// Upstream 4-phase receiver: captures one word per en phase into
// the word register and acks until the producer drops en.
module handshake_core_rx
    import handshake_core_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_en,
    input  logic             full,
    output logic             in_rdy,
    output logic             capture,
    output logic [WIDTH-1:0] word
);

    in_state_t        state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] word_q, word_d;

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        word_d  = word_q;
        capture = 1'b0;
        unique case (state_q)
            IN_IDLE: begin
                rdy_d = 1'b0;
                if (in_en && !full) begin
                    word_d  = in_data;
                    rdy_d   = 1'b1;
                    capture = 1'b1;
                    state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                // en held high never re-captures; only its fall rearms
                if (!in_en) begin
                    rdy_d   = 1'b0;
                    state_d = IN_IDLE;
                end
            end
            default: begin
                rdy_d   = 1'b0;
                state_d = IN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IN_IDLE;
            rdy_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            word_q  <= word_d;
        end
    end

    assign in_rdy = rdy_q;
    assign word   = word_q;

endmodule

// File: rtl/handshake_core.sv
// Single-entry relay: 4-phase en/rdy in, one-cycle en pulse out.
// All outputs registered; the buffer holds at most one word.
module handshake_core
    import handshake_core_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] channel_in_data,
    input  logic             channel_in_en,
    output logic             channel_in_rdy,
    output logic [WIDTH-1:0] channel_out_data,
    output logic             channel_out_en,
    input  logic             channel_out_rdy
);

    out_state_t       out_state_q, out_state_d;
    logic             full_q, full_d;
    logic             out_en_q, out_en_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             capture;
    logic [WIDTH-1:0] word;

    handshake_core_rx #(
        .WIDTH (WIDTH)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .in_data (channel_in_data),
        .in_en   (channel_in_en),
        .full    (full_q),
        .in_rdy  (channel_in_rdy),
        .capture (capture),
        .word    (word)
    );

    always_comb begin
        out_state_d = out_state_q;
        full_d      = full_q;
        out_en_d    = 1'b0;
        out_data_d  = out_data_q;
        if (capture) begin
            full_d = 1'b1;
        end
        unique case (out_state_q)
            OUT_IDLE: begin
                if (full_q && channel_out_rdy) begin
                    out_data_d  = word;
                    out_en_d    = 1'b1;
                    out_state_d = OUT_SEND;
                end
            end
            OUT_SEND: begin
                // capture cannot coincide: it is gated by full_q
                full_d      = 1'b0;
                out_state_d = OUT_IDLE;
            end
            default: begin
                out_state_d = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_state_q <= OUT_IDLE;
            full_q      <= 1'b0;
            out_en_q    <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_state_q <= out_state_d;
            full_q      <= full_d;
            out_en_q    <= out_en_d;
            out_data_q  <= out_data_d;
        end
    end

    assign channel_out_en   = out_en_q;
    assign channel_out_data = out_data_q;

endmodule

// File: tb/tb_handshake_core.sv
// Directed self-checking bench for handshake_core.
// Outputs are sampled 1 time unit after each rising edge.
module tb_handshake_core;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_en;
    logic         in_rdy;
    logic [W-1:0] out_data;
    logic         out_en;
    logic         out_rdy;

    int n_total;
    int n_pass;
    int n_in;
    int n_out;
    int n_bad;
    logic prev_rdy;
    logic prev_en;

    handshake_core #(
        .WIDTH (W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .channel_in_data  (in_data),
        .channel_in_en    (in_en),
        .channel_in_rdy   (in_rdy),
        .channel_out_data (out_data),
        .channel_out_en   (out_en),
        .channel_out_rdy  (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic rdy_e,
                            input logic en_e, input logic [W-1:0] d_e);
        chk({tag, ".in_rdy"}, {31'd0, in_rdy}, {31'd0, rdy_e});
        chk({tag, ".out_en"}, {31'd0, out_en}, {31'd0, en_e});
        chk({tag, ".out_data"}, out_data, d_e);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;
        in_en   = 1'b1;
        in_data = 32'd99;
        out_rdy = 1'b1;

        // reset held with active inputs
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs("reset", 1'b0, 1'b0, 32'd0);
        end

        // single word
        rst     = 1'b1;
        in_en   = 1'b1;
        in_data = 32'd123;
        tick();
        chk_outs("single.ack", 1'b1, 1'b0, 32'd0);
        in_en = 1'b0;
        tick();
        chk_outs("single.pulse", 1'b0, 1'b1, 32'd123);
        tick();
        chk_outs("single.after", 1'b0, 1'b0, 32'd123);
        tick();
        chk_outs("single.idle", 1'b0, 1'b0, 32'd123);

        // sticky en: one capture despite en held 10 cycles
        in_en   = 1'b1;
        in_data = 32'h77;
        n_out   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk({"sticky.rdy"}, {31'd0, in_rdy}, 32'd1);
            if (out_en) n_out++;
        end
        in_en = 1'b0;
        tick();
        chk("sticky.rdy_fall", {31'd0, in_rdy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_en) n_out++;
        end
        chk("sticky.pulses", n_out, 32'd1);
        chk("sticky.data", out_data, 32'h77);

        // backpressure
        out_rdy = 1'b0;
        in_en   = 1'b1;
        in_data = 32'hA5A5A5A5;
        tick();
        chk_outs("bp.ack1", 1'b1, 1'b0, 32'h77);
        in_en = 1'b0;
        tick();
        chk_outs("bp.drop1", 1'b0, 1'b0, 32'h77);
        in_en   = 1'b1;
        in_data = 32'h5;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_outs("bp.stall", 1'b0, 1'b0, 32'h77);
        end
        out_rdy = 1'b1;
        tick();
        chk_outs("bp.out1", 1'b0, 1'b1, 32'hA5A5A5A5);
        tick();
        chk_outs("bp.free", 1'b0, 1'b0, 32'hA5A5A5A5);
        tick();
        chk_outs("bp.ack2", 1'b1, 1'b0, 32'hA5A5A5A5);
        in_en = 1'b0;
        tick();
        chk_outs("bp.out2", 1'b0, 1'b1, 32'h5);
        tick();
        chk_outs("bp.end", 1'b0, 1'b0, 32'h5);

        // streaming with reactive producer and consumer
        n_in     = 0;
        n_out    = 0;
        n_bad    = 0;
        prev_rdy = in_rdy;
        prev_en  = out_en;
        in_data  = 32'd123;
        for (int i = 0; i < 50; i++) begin
            in_en   = ~in_rdy;
            out_rdy = ~out_en;
            tick();
            if (in_rdy && !prev_rdy) n_in++;
            if (out_en) begin
                n_out++;
                if (out_data !== 32'd123) n_bad++;
                if (prev_en) n_bad++;
            end
            prev_rdy = in_rdy;
            prev_en  = out_en;
        end
        chk("stream.rate", {31'd0, (n_out - n_in <= 1) && (n_in - n_out <= 1)},
            32'd1);
        chk("stream.min_words", {31'd0, n_in >= 10}, 32'd1);
        in_en   = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_en) begin
                n_out++;
                if (out_data !== 32'd123) n_bad++;
                if (prev_en) n_bad++;
            end
            prev_en = out_en;
        end
        chk("stream.count", n_out, n_in);
        chk("stream.bad", n_bad, 32'd0);

        // reset while a word sits in the buffer
        out_rdy = 1'b0;
        in_en   = 1'b1;
        in_data = 32'h99;
        tick();
        chk_outs("rmid.ack", 1'b1, 1'b0, 32'd123);
        rst = 1'b0;
        tick();
        chk_outs("rmid.reset", 1'b0, 1'b0, 32'd0);
        rst     = 1'b1;
        in_en   = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("rmid.discard", 1'b0, 1'b0, 32'd0);
        end
        in_en   = 1'b1;
        in_data = 32'd7;
        tick();
        chk_outs("rmid.ack7", 1'b1, 1'b0, 32'd0);
        in_en = 1'b0;
        tick();
        chk_outs("rmid.out7", 1'b0, 1'b1, 32'd7);
        tick();
        chk_outs("rmid.end", 1'b0, 1'b0, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
